// File: rtl/ss_dump_pkg.sv
// Shared defines for the save-state dump block.
// Bus widths, state encoding and parameter defaults.
package ss_dump_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 9;
  localparam int CNT_W  = 4;

  localparam int SS_LEN_DEF  = 128;
  localparam int RD_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CAPT,
    S_SEND,
    S_SUM,
    S_FIN
  } state_e;

  function automatic logic [DATA_W-1:0] neg8(
    input logic [DATA_W-1:0] v
  );
    return ~v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/ss_wait_cnt.sv
// Loadable down-counter that spaces address setup
// from the read-data capture.
module ss_wait_cnt
  import ss_dump_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ss_dump.sv
// Sweeps mapper save-state registers and streams them
// out, followed by a zero-sum checksum byte.
module ss_dump
  import ss_dump_pkg::*;
#(
  parameter int SS_LEN  = SS_LEN_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ss_addr,
  input  logic [DATA_W-1:0] ss_rdat,
  output logic              ss_act,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(SS_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LD =
    CNT_W'(RD_WAIT);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              abrt_q, abrt_d;
  logic              ld, dec;
  logic [CNT_W-1:0]  cnt;

  ss_wait_cnt u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (WAIT_LD),
    .dec_i  (dec),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    dout_d  = dout_q;
    abrt_d  = abrt_q;
    ld      = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abrt_d = 1'b0;
        if (start && !abort) begin
          state_d = S_SETUP;
          idx_d   = '0;
          csum_d  = '0;
          ld      = 1'b1;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_FIN;
          abrt_d  = 1'b1;
        end else begin
          dec = 1'b1;
          if (cnt <= CNT_W'(1))
            state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort) begin
          state_d = S_FIN;
          abrt_d  = 1'b1;
        end else begin
          dout_d  = ss_rdat;
          csum_d  = csum_q + ss_rdat;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_FIN;
          abrt_d  = 1'b1;
        end else if (dout_rdy) begin
          if (idx_q == LAST) begin
            dout_d  = neg8(csum_q);
            state_d = S_SUM;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            ld      = 1'b1;
            state_d = S_SETUP;
          end
        end
      end
      S_SUM: begin
        if (abort) begin
          state_d = S_FIN;
          abrt_d  = 1'b1;
        end else if (dout_rdy) begin
          state_d = S_FIN;
          abrt_d  = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        abrt_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      dout_q  <= '0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      dout_q  <= dout_d;
      abrt_q  <= abrt_d;
    end
  end

  assign ss_addr  = idx_q[ADDR_W-1:0];
  assign dout     = dout_q;
  assign dout_vld = (state_q == S_SEND) ||
                    (state_q == S_SUM);
  assign busy     = (state_q != S_IDLE);
  assign ss_act   = busy;
  assign done     = (state_q == S_FIN);
  assign aborted  = done && abrt_q;

endmodule

// File: doc/ss_dump.md
SS_DUMP -- requirements
Module: ss_dump

Interface
REQ-001 SHALL have parameter SS_LEN, default 128: number of save-state register addresses swept (1..256).
REQ-002 SHALL have parameter RD_WAIT, default 2: clocks ss_addr is held stable before ss_rdat is sampled (1..15).
REQ-003 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: one-clock request to begin a dump; ignored unless IDLE.
REQ-006 SHALL have port abort, input, 1: level; terminates an active dump.
REQ-007 SHALL have port ss_addr, output, 8: save-state register address presented to the mapper.
REQ-008 SHALL have port ss_rdat, input, 8: mapper save-state read data for ss_addr.
REQ-009 SHALL have port ss_act, output, 1: high while a dump is in progress (mapper register freeze).
REQ-010 SHALL have port dout, output, 8: streamed byte.
REQ-011 SHALL have port dout_vld, output, 1: dout valid.
REQ-012 SHALL have port dout_rdy, input, 1: consumer accepts dout when dout_vld and dout_rdy are both high on a rising edge.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have port done, output, 1: one-clock pulse on completion or abort.
REQ-015 SHALL have port aborted, output, 1: qualifies done; high for the same clock when termination was due to abort.

Function
REQ-016 SHALL implement states IDLE, SETUP, CAPT, SEND, SUM, FIN.
REQ-017 IDLE: start=1 -> SETUP; idx cleared to 0; checksum cleared to 0; wait counter loaded with RD_WAIT.
REQ-018 ss_addr SHALL equal idx[7:0] at all times; idx width 9 bits.
REQ-019 SETUP: wait counter decrements each clock; on reaching 0 -> CAPT. ss_addr stable for exactly RD_WAIT clocks before capture.
REQ-020 CAPT: one clock; ss_rdat registered into dout; checksum += ss_rdat modulo 256; -> SEND.
REQ-021 SEND: dout_vld=1; dout and dout_vld SHALL hold unchanged until accepted; dout_rdy may be high before dout_vld and has no effect then.
REQ-022 SEND accept: if idx==SS_LEN-1 -> SUM; else idx+1 and wait counter reloaded -> SETUP.
REQ-023 SUM: dout = two's complement of checksum (so sum of all SS_LEN+1 bytes == 0 mod 256), dout_vld=1, held until accepted -> FIN.
REQ-024 FIN: done=1, aborted=0 for one clock -> IDLE.
REQ-025 Minimum per-byte throughput: RD_WAIT+2 clocks with dout_rdy held high.
REQ-026 ss_act SHALL be 1 in SETUP, CAPT, SEND, SUM, FIN; 0 in IDLE.
REQ-027 abort=1 in any non-IDLE state except FIN -> FIN next clock with aborted=1; a byte not yet accepted is discarded; dout_vld drops the same clock FIN is entered.
REQ-028 abort and acceptance on the same edge: abort wins; the byte counts as accepted by the consumer but no further bytes are produced.
REQ-029 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-030 idx SHALL never exceed SS_LEN-1; SS_LEN=256 SHALL terminate without 8-bit ss_addr wrap.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, idx=0, ss_addr=0, checksum=0, wait counter=0, dout=0, dout_vld=0, ss_act=0, busy=0, done=0, aborted=0.
REQ-032 Reset mid-dump SHALL NOT produce done; the next start begins a full dump from address 0.

Structure
REQ-033 State encoding and SS_LEN/RD_WAIT defaults SHALL reside in the shared defines file alongside the existing bus-width definitions.
REQ-034 The block SHALL be self-contained; one optional sub-module ss_wait_cnt (loadable down-counter) is permitted.

Verification
REQ-035 SS_LEN=4, RD_WAIT=2, ss_rdat=ss_addr+8'h10, dout_rdy=1, start pulse -> bytes 10,11,12,13,BA; done one clock after BA accepted; 4*4+2 clocks start-to-last-data.
REQ-036 Same config, dout_rdy toggling 1-0-0 repeatedly -> identical byte sequence, dout stable while vld&!rdy.
REQ-037 abort asserted while second byte in SEND with dout_rdy=0 -> only byte 10 delivered, done=1 and aborted=1 same clock, ss_act low next clock.
REQ-038 rst_n pulsed low during SETUP of idx 2 -> all outputs 0 immediately, no done; new start yields full sequence from 10.
REQ-039 SS_LEN=256, ss_rdat=8'hFF -> 256 bytes FF then checksum 00; ss_addr ends at FF without wrap.
REQ-040 start pulsed again mid-dump -> ignored; sequence and byte count unchanged.
